// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC CPU fetch path: sequencer states, HLT
// encoding fields and the default machine word width.
package tsc_pkg;

    localparam int WORD = 16;

    localparam logic [3:0] OPCODE_RTYPE = 4'd15;
    localparam logic [5:0] FUNC_HLT     = 6'd29;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: reads memory at pc, issues the captured word
// as a one-cycle pulse, waits for exec_done, then advances pc. HLT stop is built only with FETCH_HALT_EN.
module instr_fetch_unit
    import tsc_pkg::*;
#(
    parameter int               WORD     = tsc_pkg::WORD,
    parameter logic [WORD-1:0]  PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            readM,
    output logic [WORD-1:0] address,
    input  logic [WORD-1:0] data,
    input  logic            inputReady,
    output logic            instr_valid,
    output logic [WORD-1:0] instruction,
    output logic [3:0]      opcode,
    output logic [5:0]      func,
    input  logic            exec_done,
    input  logic            pc_load,
    input  logic [WORD-1:0] next_pc,
    output logic [WORD-1:0] pc,
    output logic [WORD-1:0] num_inst,
    output logic            halted
);

    localparam logic [WORD-1:0] ONE = {{(WORD-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic            r_readM;
    logic            r_instr_valid;
    logic [WORD-1:0] r_instruction;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_num_inst;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_is_hlt;

    assign w_is_hlt = (r_instruction[15:12] == OPCODE_RTYPE) &&
                      (r_instruction[5:0]   == FUNC_HLT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_readM       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instruction <= '0;
            r_pc          <= PC_RESET;
            r_num_inst    <= '0;
`ifdef FETCH_HALT_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            r_instr_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_readM <= 1'b1;
                end
                S_FETCH: begin
                    if (inputReady) begin
                        r_instruction <= data;
                        r_state       <= S_ISSUE;
                        r_readM       <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_num_inst <= r_num_inst + ONE;
`ifdef FETCH_HALT_EN
                    if (w_is_hlt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
`else
                    r_state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (exec_done) begin
                        r_pc    <= pc_load ? next_pc : (r_pc + ONE);
                        r_state <= S_FETCH;
                        r_readM <= 1'b1;
                    end
                end
`ifdef FETCH_HALT_EN
                S_HALT: begin
                    r_state <= S_HALT;
                    r_readM <= 1'b0;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_readM <= 1'b0;
                end
            endcase
        end
    end

    assign readM       = r_readM;
    assign address     = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign instruction = r_instruction;
    assign opcode      = r_instruction[15:12];
    assign func        = r_instruction[5:0];
    assign num_inst    = r_num_inst;

`ifdef FETCH_HALT_EN
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed per-cycle vector bench for instr_fetch_unit, plus a hand-written HLT
// sequence whose expectations depend on FETCH_HALT_EN.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        exec_done;
    logic        pc_load;
    logic [15:0] next_pc;
    logic [15:0] pc;
    logic [15:0] num_inst;
    logic        halted;

    int unsigned n_checks;
    int unsigned n_errors;

    instr_fetch_unit #(
        .WORD     (16),
        .PC_RESET (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .readM       (readM),
        .address     (address),
        .data        (data),
        .inputReady  (inputReady),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .opcode      (opcode),
        .func        (func),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .next_pc     (next_pc),
        .pc          (pc),
        .num_inst    (num_inst),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [15:0] dat;
        logic        ed;
        logic        pl;
        logic [15:0] npc;
        logic        e_readM;
        logic        e_iv;
        logic [15:0] e_pc;
        logic [15:0] e_num;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic rst, input logic ir, input logic [15:0] dat,
                                input logic ed, input logic pl, input logic [15:0] npc,
                                input logic e_readM, input logic e_iv, input logic [15:0] e_pc,
                                input logic [15:0] e_num, input logic [15:0] e_instr);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dat = dat; v.ed = ed; v.pl = pl; v.npc = npc;
        v.e_readM = e_readM; v.e_iv = e_iv; v.e_pc = e_pc; v.e_num = e_num; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [15:0] dat,
                         input logic ed, input logic pl, input logic [15:0] npc);
        reset = rst; inputReady = ir; data = dat;
        exec_done = ed; pc_load = pl; next_pc = npc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ei;
        n_checks = 0;
        n_errors = 0;
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

        //                 rst  ir    data      ed    pl    npc        readM iv    pc        num       instr
        vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[1]  = mk(1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[4]  = mk(1'b0, 1'b1, 16'hF01C, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hF01C);
        vecs[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hF01C);
        vecs[6]  = mk(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hF01C);
        vecs[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'hF01C);
        vecs[8]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h1234);
        vecs[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h1234);
        vecs[10] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0004, 16'h0002, 16'h1234);
        vecs[11] = mk(1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h0002, 16'h2000);
        vecs[12] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0003, 16'h2000);
        vecs[13] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0003, 16'h2000);
        vecs[14] = mk(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 16'h0003, 16'h3000);
        vecs[15] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 16'h0004, 16'h3000);
        vecs[16] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0040, 16'h0004, 16'h3000);
        vecs[17] = mk(1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h0004, 16'h4000);
        vecs[18] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0005, 16'h4000);
        vecs[19] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0005, 16'h4000);
        vecs[20] = mk(1'b0, 1'b1, 16'h5000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0005, 16'h5000);
        vecs[21] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0006, 16'h5000);
        vecs[22] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'h5000);
        vecs[23] = mk(1'b0, 1'b1, 16'h6000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0006, 16'h6000);
        vecs[24] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0007, 16'h6000);
        vecs[25] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0100, 16'h0007, 16'h6000);
        vecs[26] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[27] = mk(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        vecs[28] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].rst, vecs[i].ir, vecs[i].dat, vecs[i].ed, vecs[i].pl, vecs[i].npc);
            step();
            ei = vecs[i].e_instr;
            chk($sformatf("v%0d.readM", i),       {31'd0, readM},       {31'd0, vecs[i].e_readM});
            chk($sformatf("v%0d.instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_iv});
            chk($sformatf("v%0d.pc", i),          {16'd0, pc},          {16'd0, vecs[i].e_pc});
            chk($sformatf("v%0d.address", i),     {16'd0, address},     {16'd0, vecs[i].e_pc});
            chk($sformatf("v%0d.num_inst", i),    {16'd0, num_inst},    {16'd0, vecs[i].e_num});
            chk($sformatf("v%0d.instruction", i), {16'd0, instruction}, {16'd0, ei});
            chk($sformatf("v%0d.opcode", i),      {28'd0, opcode},      {28'd0, ei[15:12]});
            chk($sformatf("v%0d.func", i),        {26'd0, func},        {26'd0, ei[5:0]});
            chk($sformatf("v%0d.halted", i),      {31'd0, halted},      32'd0);
        end

        // First instruction after reset: F01C decodes as opcode 15, func 28.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step();
        drive(1'b0, 1'b1, 16'hF01C, 1'b0, 1'b0, 16'h0);
        step();
        chk("f01c.iv",     {31'd0, instr_valid}, 32'd1);
        chk("f01c.opcode", {28'd0, opcode},      32'd15);
        chk("f01c.func",   {26'd0, func},        32'd28);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step();
        chk("f01c.iv_drop", {31'd0, instr_valid}, 32'd0);
        chk("f01c.num",     {16'd0, num_inst},    32'd1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        step();
        chk("f01c.pc", {16'd0, pc}, 32'd1);

        // HLT word F01D fetched at pc=1.
        drive(1'b0, 1'b1, 16'hF01D, 1'b0, 1'b0, 16'h0);
        step();
        chk("hlt.iv",     {31'd0, instr_valid}, 32'd1);
        chk("hlt.opcode", {28'd0, opcode},      32'd15);
        chk("hlt.func",   {26'd0, func},        32'd29);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step();
        chk("hlt.num", {16'd0, num_inst}, 32'd2);
`ifdef FETCH_HALT_EN
        chk("hlt.halted", {31'd0, halted}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b1, 16'h1111, 1'b1, c[0], 16'h0033);
            step();
            chk($sformatf("hlt.c%0d.readM", c),  {31'd0, readM},       32'd0);
            chk($sformatf("hlt.c%0d.halted", c), {31'd0, halted},      32'd1);
            chk($sformatf("hlt.c%0d.iv", c),     {31'd0, instr_valid}, 32'd0);
            chk($sformatf("hlt.c%0d.pc", c),     {16'd0, pc},          32'd1);
            chk($sformatf("hlt.c%0d.num", c),    {16'd0, num_inst},    32'd2);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step();
        chk("hlt.rst_halted", {31'd0, halted}, 32'd0);
        chk("hlt.rst_pc",     {16'd0, pc},     32'd0);
`else
        chk("hlt.halted", {31'd0, halted}, 32'd0);
        chk("hlt.readM",  {31'd0, readM},  32'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        step();
        chk("hlt.next_readM", {31'd0, readM},  32'd1);
        chk("hlt.next_pc",    {16'd0, pc},     32'd2);
        chk("hlt.no_halt",    {31'd0, halted}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
